// File: rtl/derate_matching_inbuf_writer.sv
// Round-robin writer for the 16-bank de-rate-matching input buffer; DRM_INBUF_WR_OVF_CHK_EN adds an oversize-length reject.
// Writes appear one cycle after accept; ready is high only while filling, so stalls come solely from i_in_valid.
module derate_matching_inbuf_writer #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 11,
  parameter int LEN_W  = ADDR_W + 5
) (
  input  logic                 i_core_clk,
  input  logic                 i_rx_rst,
  input  logic                 i_cw_start,
  input  logic [LEN_W-1:0]     i_cw_len,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [DATA_W-1:0]    i_in_data,
  output logic [DATA_W-1:0]    o_wr_addr,
  output logic [16*DATA_W-1:0] o_wr_data,
  output logic [15:0]          o_wr_en,
  output logic                 o_busy,
  output logic                 o_cw_done,
  output logic [ADDR_W:0]      o_rows,
  output logic                 o_err
);

  typedef enum logic [1:0] {IDLE, FILL, PAD, DONE} state_t;

  state_t            state;
  logic [3:0]        bank;
  logic [ADDR_W-1:0] row;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  cwLen;
  logic [LEN_W:0]    rowsCeil;
  logic              lenReject;

`ifdef DRM_INBUF_WR_OVF_CHK_EN
  // Largest codeword that fits: every row of every bank.
  localparam logic [LEN_W-1:0] maxLen = LEN_W'(1) << (ADDR_W + 4);
  assign lenReject = (i_cw_len > maxLen);
`else
  assign lenReject = 1'b0;
`endif

  assign rowsCeil   = ({1'b0, cwLen} + (LEN_W+1)'(15)) >> 4;
  assign o_in_ready = (state == FILL);
  assign o_busy     = (state != IDLE);

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state     <= IDLE;
      bank      <= '0;
      row       <= '0;
      count     <= '0;
      cwLen     <= '0;
      o_wr_en   <= '0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_cw_done <= 1'b0;
      o_rows    <= '0;
      o_err     <= 1'b0;
    end else begin
      o_wr_en   <= '0;
      o_cw_done <= 1'b0;
      o_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cw_start) begin
            if (lenReject) begin
              o_err <= 1'b1;
            end else begin
              cwLen  <= i_cw_len;
              bank   <= '0;
              row    <= '0;
              count  <= '0;
              o_rows <= '0;
              state  <= (i_cw_len == '0) ? DONE : FILL;
            end
          end
        end
        FILL: begin
          if (i_in_valid) begin
            o_wr_en   <= 16'(1) << bank;
            o_wr_addr <= DATA_W'(row);
            o_wr_data <= {16{i_in_data}};
            bank      <= bank + 4'd1;
            count     <= count + LEN_W'(1);
            if (bank == 4'd15) row <= row + ADDR_W'(1);
            // Last word: a completed row needs no padding.
            if (count + LEN_W'(1) == cwLen) state <= (bank == 4'd15) ? DONE : PAD;
          end
        end
        PAD: begin
          o_wr_en   <= 16'(1) << bank;
          o_wr_addr <= DATA_W'(row);
          o_wr_data <= '0;
          bank      <= bank + 4'd1;
          if (bank == 4'd15) begin
            row   <= row + ADDR_W'(1);
            state <= DONE;
          end
        end
        DONE: begin
          o_cw_done <= 1'b1;
          o_rows    <= rowsCeil[ADDR_W:0];
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_derate_matching_inbuf_writer.sv
// Bench for derate_matching_inbuf_writer: table of codewords plus random gaps/data, checked cycle by cycle
// against a word-index model (word i -> bank i%16, row i/16, then zero pad to a full row).
module tb_derate_matching_inbuf_writer;
  localparam int DATA_W = 48;
  localparam int ADDR_W = 11;
  localparam int LEN_W  = ADDR_W + 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cw_start;
  logic [LEN_W-1:0]     cw_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic [DATA_W-1:0]    wr_addr;
  logic [16*DATA_W-1:0] wr_data;
  logic [15:0]          wr_en;
  logic                 busy;
  logic                 cw_done;
  logic [ADDR_W:0]      rows;
  logic                 err;

  int vecs = 0;
  int miscompares = 0;
  int curLen = 0;
  int curCyc = 0;

  always #5 clk = ~clk;

  derate_matching_inbuf_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .i_core_clk(clk),
    .i_rx_rst  (rst),
    .i_cw_start(cw_start),
    .i_cw_len  (cw_len),
    .i_in_valid(in_valid),
    .o_in_ready(in_ready),
    .i_in_data (in_data),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_wr_en   (wr_en),
    .o_busy    (busy),
    .o_cw_done (cw_done),
    .o_rows    (rows),
    .o_err     (err)
  );

  typedef struct {
    int len;
    int gapPct;
    bit midStart;
    int expRows;
  } cw_vec_t;

  cw_vec_t tbl[7];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (len=%0d cyc=%0d): got %h, expected %h", name, curLen, curCyc, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, "_ctrl"}, 64'({wr_en, in_ready, busy, cw_done, err}), 64'(0));
    cmp({tag, "_addr"}, 64'(wr_addr), 64'(0));
    cmp({tag, "_data_nonzero"}, 64'(|wr_data), 64'(0));
    cmp({tag, "_rows"}, 64'(rows), 64'(0));
  endtask

  // One codeword, checked every cycle from the start cycle (k=0) to the done cycle.
  task automatic run_cw(input int len, input int gapPct, input bit midStart, input int expRows);
    logic [DATA_W-1:0] dataQ[$];
    logic [DATA_W-1:0] expWord;
    logic [63:0]       expAddr;
    logic [15:0]       expEn;
    int  total, accepted, written, doneAt, limit, k;
    bit  prevAcc, isW, expReady, expBusy, expDone;
    total    = ((len + 15) / 16) * 16;
    accepted = 0;
    written  = 0;
    prevAcc  = 1'b0;
    doneAt   = (len == 0) ? 2 : -1;
    limit    = 4 * len + 60;
    curLen   = len;
    k        = 0;
    while (1) begin
      if (k > limit) begin
        vecs++;
        miscompares++;
        $display("FAIL timeout (len=%0d): got no done by cycle %0d, expected within %0d", len, k, limit);
        break;
      end
      @(posedge clk); #1;
      cw_start = (k == 0) || (midStart && k == 3);
      cw_len   = (k == 0) ? LEN_W'(len) : LEN_W'(1);
      in_valid = (k >= 1) && (accepted < len) && ($urandom_range(99) >= gapPct);
      in_data  = DATA_W'({$urandom(), $urandom()});
      @(negedge clk);
      curCyc = k;

      isW     = 1'b0;
      expEn   = '0;
      expAddr = '0;
      expWord = '0;
      if (prevAcc) begin
        isW     = 1'b1;
        expWord = dataQ.pop_front();
      end else if (accepted == len && written >= len && written < total) begin
        isW = 1'b1;
      end
      if (isW) begin
        expEn   = 16'(1) << (written % 16);
        expAddr = 64'((written / 16) % (1 << ADDR_W));
        written++;
        if (written == total) doneAt = k + 1;
      end
      expDone  = (k == doneAt);
      expBusy  = (k >= 1) && (doneAt < 0 || k < doneAt);
      expReady = (k >= 1) && (accepted < len);

      cmp("ctrl{en,rdy,busy,done,err}", 64'({wr_en, in_ready, busy, cw_done, err}),
          64'({expEn, expReady, expBusy, expDone, 1'b0}));
      if (isW) begin
        cmp("wr_addr", 64'(wr_addr), expAddr);
        for (int s = 0; s < 16; s++)
          cmp("wr_data", 64'(wr_data[s*DATA_W +: DATA_W]), 64'(expWord));
      end
      if (expDone) begin
        cmp("rows", 64'(rows), 64'(expRows));
        break;
      end
      prevAcc = in_valid && in_ready;
      if (prevAcc) begin
        dataQ.push_back(in_data);
        accepted++;
      end
      k++;
    end
    #1;
    cw_start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32, 0, 1'b0, 2};
    tbl[1] = '{20, 0, 1'b0, 2};
    tbl[2] = '{5, 50, 1'b0, 1};
    tbl[3] = '{0, 0, 1'b0, 0};
    tbl[4] = '{40, 20, 1'b1, 3};
    tbl[5] = '{17, 30, 1'b0, 2};
    tbl[6] = '{1, 0, 1'b0, 1};

    rst      = 1'b1;
    cw_start = 1'b0;
    cw_len   = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_cw(tbl[i].len, tbl[i].gapPct, tbl[i].midStart, tbl[i].expRows);

    for (int i = 0; i < 6; i++) begin
      int len;
      len = $urandom_range(80, 1);
      run_cw(len, $urandom_range(40, 0), 1'b0, (len + 15) / 16);
    end

    // Abort after 7 of 16 words, then a clean codeword from row 0.
    curLen = 16;
    @(posedge clk); #1;
    cw_start = 1'b1;
    cw_len   = LEN_W'(16);
    @(posedge clk); #1;
    cw_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'({$urandom(), $urandom()});
      @(negedge clk);
      curCyc = i + 1;
      cmp("abort_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    cmp("abort_last_en", 64'(wr_en), 64'(16'h0040));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("abort");
    run_cw(16, 0, 1'b0, 1);

`ifdef DRM_INBUF_WR_OVF_CHK_EN
    curLen = 32769;
    @(posedge clk); #1;
    cw_start = 1'b1;
    cw_len   = LEN_W'(32769);
    @(posedge clk); #1;
    cw_start = 1'b0;
    @(negedge clk);
    cmp("ovf{err,busy,rdy}", 64'({err, busy, in_ready}), 64'(3'b100));
    @(posedge clk); #1;
    @(negedge clk);
    cmp("ovf_pulse{err,busy,rdy}", 64'({err, busy, in_ready}), 64'(3'b000));
    run_cw(3, 0, 1'b0, 1);
`else
    run_cw(32784, 0, 1'b0, 2049);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
